key_entry_ctrl: RTL

Sequencer between the keypad decoder and the lock logic. It captures one key per ReadyKey assertion and acknowledges each key by pulsing RstKey, which clears the decoder. It accumulates DIGITS decimal digits and compares them against the stored Code, then reports Match or Fail. After MAX_FAIL consecutive failures it enforces a timed lockout.

---
 rtl/key_entry_ctrl_if.sv | 26 ++
 rtl/key_entry_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/key_entry_ctrl_if.sv
// Signal bundle between the keypad decoder/lock logic and key_entry_ctrl.
// The master side drives keys and the stored code. The slave side is the controller.
interface key_entry_ctrl_if #(
  parameter int DIGITS = 4
);
  localparam int CW = $clog2(DIGITS + 1);

  logic              ReadyKey;
  logic [3:0]        KeyCode;
  logic [4*DIGITS-1:0] Code;
  logic              RstKey;
  logic              Match;
  logic              Fail;
  logic              Locked;
  logic [CW-1:0]     DigitCount;

  modport master (
    output ReadyKey, KeyCode, Code,
    input  RstKey, Match, Fail, Locked, DigitCount
  );

  modport slave (
    input  ReadyKey, KeyCode, Code,
    output RstKey, Match, Fail, Locked, DigitCount
  );
endinterface

// File: rtl/key_entry_ctrl.sv
// Key entry sequencer: captures one key per ReadyKey level and acknowledges it with RstKey.
// It accumulates DIGITS digits, compares them with Code, and enforces a timed lockout after repeated failures.
module key_entry_ctrl #(
  parameter int         DIGITS      = 4,
  parameter int         MAX_FAIL    = 3,
  parameter int         LOCK_CYCLES = 1000,
  parameter logic [3:0] CLR_KEY     = 4'hC
) (
  input logic             Clk,
  input logic             Rst,
  key_entry_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ACK, RELEASE, CHECK, LOCK} stateT;

  stateT               state, stateNext;
  logic [4*DIGITS-1:0] entry, entryNext, entryShift;
  logic [CW-1:0]       cnt, cntNext;
  logic [FW-1:0]       fails, failsNext, failsInc;
  logic [TW-1:0]       ltimer, ltimerNext;
  logic                readyQ;
  logic                isDigit;
  logic                codeEq;

  // A one-digit code has no older digits to shift along.
  generate
    if (DIGITS == 1) begin : gShiftSingle
      assign entryShift = bus.KeyCode;
    end else begin : gShiftMulti
      assign entryShift = {entry[4*DIGITS-5:0], bus.KeyCode};
    end
  endgenerate

  assign isDigit  = (bus.KeyCode <= 4'd9);
  assign codeEq   = (entry == bus.Code);
  assign failsInc = fails + 1'b1;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      entry  <= '0;
      cnt    <= '0;
      fails  <= '0;
      ltimer <= '0;
      readyQ <= 1'b0;
    end else begin
      state  <= stateNext;
      entry  <= entryNext;
      cnt    <= cntNext;
      fails  <= failsNext;
      ltimer <= ltimerNext;
      readyQ <= bus.ReadyKey;
    end
  end

  always_comb begin
    stateNext  = state;
    entryNext  = entry;
    cntNext    = cnt;
    failsNext  = fails;
    ltimerNext = ltimer;
    case (state)
      IDLE: begin
        if (bus.ReadyKey) begin
          stateNext = ACK;
          if (isDigit) begin
            entryNext = entryShift;
            cntNext   = cnt + 1'b1;
          end else if (bus.KeyCode == CLR_KEY) begin
            entryNext = '0;
            cntNext   = '0;
          end
        end
      end
      ACK: stateNext = RELEASE;
      RELEASE: begin
        // Wait for the decoder to drop the key, so a held key is captured only once.
        if (!bus.ReadyKey) begin
          stateNext = (cnt == CW'(DIGITS)) ? CHECK : IDLE;
        end
      end
      CHECK: begin
        entryNext = '0;
        cntNext   = '0;
        if (codeEq) begin
          failsNext = '0;
          stateNext = IDLE;
        end else begin
          failsNext = failsInc;
          if (failsInc == FW'(MAX_FAIL)) begin
            ltimerNext = TW'(LOCK_CYCLES - 1);
            stateNext  = LOCK;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      LOCK: begin
        if (ltimer == '0) begin
          failsNext = '0;
          stateNext = IDLE;
        end else begin
          ltimerNext = ltimer - 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // During lockout, keys are drained by echoing the registered ReadyKey.
  assign bus.RstKey     = (state == ACK) || ((state == LOCK) && readyQ);
  assign bus.Match      = (state == CHECK) && codeEq;
  assign bus.Fail       = (state == CHECK) && !codeEq;
  assign bus.Locked     = (state == LOCK);
  assign bus.DigitCount = cnt;
endmodule
